// File: rtl/router_ctrl.sv
// Sequencing controller of the 1x3 router: header decode, FIFO write strobes,
// source throttling, and packet parity check. The per-port read timeout and
// the soft_reset flush pulses are built only when ROUTER_SOFT_RESET_EN is defined.
module router_ctrl #(
  parameter int unsigned TIMEOUT = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  input  logic [2:0] fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] read_enb,
  output logic [2:0] write_enb,
  output logic [7:0] hold_data,
  output logic       lfd_state,
  output logic       laf_state,
  output logic       busy,
  output logic       error,
  output logic [2:0] soft_reset
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    WAIT_TILL_EMPTY,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    CHECK_PARITY_ERROR
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic [7:0] parity_q, parity_d;
  logic [7:0] pkt_parity_q, pkt_parity_d;
  logic [7:0] hold_data_q, hold_data_d;
  logic       hold_last_q, hold_last_d;
  logic       error_q, error_d;

  logic [2:0] addr_oh;
  logic       hdr_empty;
  logic       sel_empty;
  logic       sel_full;
  logic       wr;
  logic       abort;

  // Both lookups go through one-hot masks, so addr 3 can never index past [2:0].
  always_comb begin
    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    addr_oh   = 3'b000;
    hdr_empty = 1'b0;
    case (addr_q)
      2'd0:    addr_oh = 3'b001;
      2'd1:    addr_oh = 3'b010;
      2'd2:    addr_oh = 3'b100;
      default: addr_oh = 3'b000;
    endcase
    case (data_in[1:0])
      2'd0:    hdr_empty = fifo_empty[0];
      2'd1:    hdr_empty = fifo_empty[1];
      2'd2:    hdr_empty = fifo_empty[2];
      default: hdr_empty = 1'b0;
    endcase
  end

  assign sel_empty = |(fifo_empty & addr_oh);
  assign sel_full  = |(fifo_full & addr_oh);

`ifdef ROUTER_SOFT_RESET_EN
  localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

  logic [2:0][7:0] cnt_q, cnt_d;
  logic [2:0]      soft_reset_q, soft_reset_d;

  // A port times out only while it has data to offer and nobody is reading it.
  always_comb begin
    cnt_d        = cnt_q;
    soft_reset_d = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (read_enb[i] || fifo_empty[i]) begin
        cnt_d[i] = 8'd0;
      end else if (cnt_q[i] == CNT_MAX) begin
        cnt_d[i]        = 8'd0;
        soft_reset_d[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      soft_reset_q <= 3'b000;
    end else begin
      cnt_q        <= cnt_d;
      soft_reset_q <= soft_reset_d;
    end
  end

  assign soft_reset = soft_reset_q;
  assign abort      = (state_q != DECODE_ADDRESS) && |(soft_reset_q & addr_oh);
`else
  logic unused_cfg;
  assign unused_cfg = ^{read_enb, 8'(TIMEOUT)};
  assign soft_reset = 3'b000;
  assign abort      = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    parity_d     = parity_q;
    pkt_parity_d = pkt_parity_q;
    hold_data_d  = hold_data_q;
    hold_last_d  = hold_last_q;
    error_d      = error_q;
    wr           = 1'b0;
    busy         = 1'b0;
    lfd_state    = 1'b0;
    laf_state    = 1'b0;

    case (state_q)
      DECODE_ADDRESS: begin
        if (pkt_valid && (data_in[1:0] != 2'd3)) begin
          addr_d   = data_in[1:0];
          parity_d = data_in;
          state_d  = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      WAIT_TILL_EMPTY: begin
        busy = 1'b1;
        if (sel_empty) state_d = LOAD_FIRST_DATA;
      end
      LOAD_FIRST_DATA: begin
        busy      = 1'b1;
        lfd_state = 1'b1;
        wr        = 1'b1;
        error_d   = 1'b0;
        state_d   = LOAD_DATA;
      end
      LOAD_DATA: begin
        // A byte that meets a full FIFO is parked in hold_data, parity byte included.
        if (sel_full) begin
          hold_data_d = data_in;
          hold_last_d = ~pkt_valid;
          state_d     = FIFO_FULL_STATE;
        end else begin
          wr = 1'b1;
          if (pkt_valid) begin
            parity_d = parity_q ^ data_in;
          end else begin
            pkt_parity_d = data_in;
            state_d      = CHECK_PARITY_ERROR;
          end
        end
      end
      FIFO_FULL_STATE: begin
        busy = 1'b1;
        if (!sel_full) state_d = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        busy      = 1'b1;
        laf_state = 1'b1;
        wr        = 1'b1;
        if (hold_last_q) begin
          pkt_parity_d = hold_data_q;
          state_d      = CHECK_PARITY_ERROR;
        end else begin
          parity_d = parity_q ^ hold_data_q;
          state_d  = LOAD_DATA;
        end
      end
      CHECK_PARITY_ERROR: begin
        busy    = 1'b1;
        error_d = (parity_q != pkt_parity_q);
        state_d = DECODE_ADDRESS;
      end
      default: state_d = DECODE_ADDRESS;
    endcase

    // A flushed destination abandons the packet: no write, no bookkeeping, error kept.
    if (abort) begin
      state_d      = DECODE_ADDRESS;
      wr           = 1'b0;
      addr_d       = addr_q;
      parity_d     = parity_q;
      pkt_parity_d = pkt_parity_q;
      hold_data_d  = hold_data_q;
      hold_last_d  = hold_last_q;
      error_d      = error_q;
    end
  end

  assign write_enb = wr ? addr_oh : 3'b000;
  assign hold_data = hold_data_q;
  assign error     = error_q;

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q      <= DECODE_ADDRESS;
      addr_q       <= 2'd0;
      parity_q     <= 8'd0;
      pkt_parity_q <= 8'd0;
      hold_data_q  <= 8'd0;
      hold_last_q  <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      parity_q     <= parity_d;
      pkt_parity_q <= pkt_parity_d;
      hold_data_q  <= hold_data_d;
      hold_last_q  <= hold_last_d;
      error_q      <= error_d;
    end
  end

endmodule

// File: tb/tb_router_ctrl.sv
// Directed bench for router_ctrl: packet flow, parity error, wait-for-empty,
// full/hold path, illegal address, async reset, and read timeout (ROUTER_SOFT_RESET_EN).
module tb_router_ctrl;
  localparam int TIMEOUT = 30;

  logic       clock = 1'b0;
  logic       reset;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic [2:0] fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] read_enb;
  logic [2:0] write_enb;
  logic [7:0] hold_data;
  logic       lfd_state;
  logic       laf_state;
  logic       busy;
  logic       error;
  logic [2:0] soft_reset;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt [3] = '{0, 0, 0};
  logic [7:0] wr_log [$];

  router_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .read_enb(read_enb),
    .write_enb(write_enb), .hold_data(hold_data), .lfd_state(lfd_state),
    .laf_state(laf_state), .busy(busy), .error(error), .soft_reset(soft_reset)
  );

  always #5 clock = ~clock;

  // Records what FIFO0 would store (hold_data on laf, data_in otherwise), headers excluded.
  always @(negedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) if (write_enb[i]) wr_cnt[i] <= wr_cnt[i] + 1;
      if (write_enb[0] && !lfd_state) wr_log.push_back(laf_state ? hold_data : data_in);
    end
  end

  // Drives one cycle's inputs just after the rising edge, returns at the falling edge.
  task automatic tick(input logic pv, input logic [7:0] d, input logic [2:0] full,
                      input logic [2:0] empty, input logic [2:0] renb);
    @(posedge clock);
    #1;
    pkt_valid  = pv;
    data_in    = d;
    fifo_full  = full;
    fifo_empty = empty;
    read_enb   = renb;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; pkt_valid = 1'b0; data_in = 8'h00;
    fifo_full = 3'b000; fifo_empty = 3'b111; read_enb = 3'b000;
    repeat (2) @(negedge clock);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (write_enb !== 3'b000) begin n_bad++; $display("FAIL reset_write: got %b want 000", write_enb); end
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL reset_error: got %b want 0", error); end
    n_cmp++; if (hold_data !== 8'h00) begin n_bad++; $display("FAIL reset_hold: got %h want 00", hold_data); end
    n_cmp++; if (soft_reset !== 3'b000) begin n_bad++; $display("FAIL reset_soft: got %b want 000", soft_reset); end
    n_cmp++; if ({lfd_state, laf_state} !== 2'b00) begin n_bad++; $display("FAIL reset_markers: got %b want 00", {lfd_state, laf_state}); end
    reset = 1'b0;
    tick(1'b0, 8'h00, 3'b000, 3'b111, 3'b000);
  endtask

  task automatic test_good_packet();
    int w0;
    w0 = wr_cnt[1];
    tick(1'b1, 8'h05, 3'b000, 3'b111, 3'b000);
    n_cmp++; if ({busy, write_enb} !== 4'b0000) begin n_bad++; $display("FAIL good_decode: got %b want 0000", {busy, write_enb}); end
    tick(1'b1, 8'hA5, 3'b000, 3'b111, 3'b000);
    n_cmp++; if ({busy, lfd_state, write_enb} !== 5'b11010) begin n_bad++; $display("FAIL good_lfd: got %b want 11010", {busy, lfd_state, write_enb}); end
    tick(1'b1, 8'hA5, 3'b000, 3'b111, 3'b000);
    n_cmp++; if ({busy, lfd_state, write_enb} !== 5'b00010) begin n_bad++; $display("FAIL good_payload: got %b want 00010", {busy, lfd_state, write_enb}); end
    tick(1'b0, 8'hA0, 3'b000, 3'b111, 3'b000);
    n_cmp++; if ({busy, write_enb} !== 4'b0010) begin n_bad++; $display("FAIL good_parity_wr: got %b want 0010", {busy, write_enb}); end
    tick(1'b0, 8'h00, 3'b000, 3'b111, 3'b000);
    n_cmp++; if ({busy, write_enb} !== 4'b1000) begin n_bad++; $display("FAIL good_check: got %b want 1000", {busy, write_enb}); end
    tick(1'b0, 8'h00, 3'b000, 3'b111, 3'b000);
    n_cmp++; if ({busy, error} !== 2'b00) begin n_bad++; $display("FAIL good_done: got %b want 00", {busy, error}); end
    n_cmp++; if (wr_cnt[1] - w0 !== 3) begin n_bad++; $display("FAIL good_wr_count: got %0d want 3", wr_cnt[1] - w0); end
  endtask

  task automatic test_parity_error();
    tick(1'b1, 8'h05, 3'b000, 3'b111, 3'b000);
    tick(1'b1, 8'hA5, 3'b000, 3'b111, 3'b000);
    tick(1'b1, 8'hA5, 3'b000, 3'b111, 3'b000);
    tick(1'b0, 8'hA1, 3'b000, 3'b111, 3'b000);
    tick(1'b0, 8'h00, 3'b000, 3'b111, 3'b000);
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL perr_early: got %b want 0", error); end
    tick(1'b0, 8'h00, 3'b000, 3'b111, 3'b000);
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL perr_set: got %b want 1", error); end
    tick(1'b1, 8'h05, 3'b000, 3'b111, 3'b000);
    tick(1'b1, 8'hA5, 3'b000, 3'b111, 3'b000);
    n_cmp++; if ({lfd_state, error} !== 2'b11) begin n_bad++; $display("FAIL perr_hold_lfd: got %b want 11", {lfd_state, error}); end
    tick(1'b1, 8'hA5, 3'b000, 3'b111, 3'b000);
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL perr_clear: got %b want 0", error); end
    tick(1'b0, 8'hA0, 3'b000, 3'b111, 3'b000);
    tick(1'b0, 8'h00, 3'b000, 3'b111, 3'b000);
    tick(1'b0, 8'h00, 3'b000, 3'b111, 3'b000);
    n_cmp++; if ({busy, error} !== 2'b00) begin n_bad++; $display("FAIL perr_next_ok: got %b want 00", {busy, error}); end
  endtask

  task automatic test_wait_empty();
    int w2;
    w2 = wr_cnt[2];
    tick(1'b1, 8'h02, 3'b000, 3'b011, 3'b000);
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 8'h02, 3'b000, (k == 2) ? 3'b111 : 3'b011, 3'b000);
      n_cmp++; if ({busy, write_enb} !== 4'b1000) begin n_bad++; $display("FAIL wait_hold%0d: got %b want 1000", k, {busy, write_enb}); end
    end
    tick(1'b0, 8'h02, 3'b000, 3'b111, 3'b000);
    n_cmp++; if ({lfd_state, write_enb} !== 4'b1100) begin n_bad++; $display("FAIL wait_hdr_wr: got %b want 1100", {lfd_state, write_enb}); end
    tick(1'b0, 8'h02, 3'b000, 3'b111, 3'b000);
    tick(1'b0, 8'h00, 3'b000, 3'b111, 3'b000);
    tick(1'b0, 8'h00, 3'b000, 3'b111, 3'b000);
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL wait_error: got %b want 0", error); end
    n_cmp++; if (wr_cnt[2] - w2 !== 2) begin n_bad++; $display("FAIL wait_wr_count: got %0d want 2", wr_cnt[2] - w2); end
  endtask

  task automatic test_fifo_full();
    logic [7:0] exp_log [5];
    exp_log = '{8'h11, 8'h22, 8'h3C, 8'h44, 8'h5B};
    wr_log.delete();
    tick(1'b1, 8'h10, 3'b000, 3'b111, 3'b000);
    tick(1'b1, 8'h11, 3'b000, 3'b111, 3'b000);
    tick(1'b1, 8'h11, 3'b000, 3'b111, 3'b000);
    tick(1'b1, 8'h22, 3'b000, 3'b111, 3'b000);
    tick(1'b1, 8'h3C, 3'b001, 3'b111, 3'b000);
    n_cmp++; if ({busy, write_enb} !== 4'b0000) begin n_bad++; $display("FAIL full_nowrite: got %b want 0000", {busy, write_enb}); end
    tick(1'b1, 8'h44, 3'b001, 3'b111, 3'b000);
    n_cmp++; if ({busy, write_enb} !== 4'b1000) begin n_bad++; $display("FAIL full_stall: got %b want 1000", {busy, write_enb}); end
    tick(1'b1, 8'h44, 3'b000, 3'b111, 3'b000);
    tick(1'b1, 8'h44, 3'b000, 3'b111, 3'b000);
    n_cmp++; if ({busy, laf_state, write_enb} !== 5'b11001) begin n_bad++; $display("FAIL full_laf: got %b want 11001", {busy, laf_state, write_enb}); end
    n_cmp++; if (hold_data !== 8'h3C) begin n_bad++; $display("FAIL full_hold_data: got %h want 3c", hold_data); end
    tick(1'b1, 8'h44, 3'b000, 3'b111, 3'b000);
    n_cmp++; if ({laf_state, write_enb} !== 4'b0001) begin n_bad++; $display("FAIL full_resume: got %b want 0001", {laf_state, write_enb}); end
    tick(1'b0, 8'h5B, 3'b000, 3'b111, 3'b000);
    tick(1'b0, 8'h00, 3'b000, 3'b111, 3'b000);
    tick(1'b0, 8'h00, 3'b000, 3'b111, 3'b000);
    n_cmp++; if ({busy, error} !== 2'b00) begin n_bad++; $display("FAIL full_parity: got %b want 00", {busy, error}); end
    n_cmp++; if (wr_log.size() !== 5) begin n_bad++; $display("FAIL full_log_size: got %0d want 5", wr_log.size()); end
    for (int i = 0; i < 5 && i < wr_log.size(); i++) begin
      n_cmp++; if (wr_log[i] !== exp_log[i]) begin n_bad++; $display("FAIL full_log%0d: got %h want %h", i, wr_log[i], exp_log[i]); end
    end
  endtask

  task automatic test_full_on_parity();
    int w1;
    w1 = wr_cnt[1];
    tick(1'b1, 8'h01, 3'b000, 3'b111, 3'b000);
    tick(1'b0, 8'h01, 3'b000, 3'b111, 3'b000);
    tick(1'b0, 8'h01, 3'b010, 3'b111, 3'b000);
    n_cmp++; if (write_enb !== 3'b000) begin n_bad++; $display("FAIL fpar_nowrite: got %b want 000", write_enb); end
    tick(1'b0, 8'h00, 3'b000, 3'b111, 3'b000);
    tick(1'b0, 8'h00, 3'b000, 3'b111, 3'b000);
    n_cmp++; if ({laf_state, write_enb, hold_data} !== {4'b1010, 8'h01}) begin n_bad++; $display("FAIL fpar_laf: got %b/%h want 1010/01", {laf_state, write_enb}, hold_data); end
    tick(1'b0, 8'h00, 3'b000, 3'b111, 3'b000);
    n_cmp++; if ({busy, laf_state, write_enb} !== 5'b10000) begin n_bad++; $display("FAIL fpar_check: got %b want 10000", {busy, laf_state, write_enb}); end
    tick(1'b0, 8'h00, 3'b000, 3'b111, 3'b000);
    n_cmp++; if ({busy, error} !== 2'b00) begin n_bad++; $display("FAIL fpar_done: got %b want 00", {busy, error}); end
    n_cmp++; if (wr_cnt[1] - w1 !== 2) begin n_bad++; $display("FAIL fpar_wr_count: got %0d want 2", wr_cnt[1] - w1); end
  endtask

  task automatic test_bad_addr();
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 8'h03, 3'b000, 3'b111, 3'b000);
      n_cmp++; if ({busy, lfd_state, write_enb} !== 5'b00000) begin n_bad++; $display("FAIL badaddr%0d: got %b want 00000", k, {busy, lfd_state, write_enb}); end
    end
    tick(1'b0, 8'h00, 3'b000, 3'b111, 3'b000);
  endtask

  task automatic test_async_reset();
    // Header 01 with parity 00 mismatches, so error rises and survives into the next wait.
    tick(1'b1, 8'h01, 3'b000, 3'b111, 3'b000);
    tick(1'b0, 8'h00, 3'b000, 3'b111, 3'b000);
    tick(1'b0, 8'h00, 3'b000, 3'b111, 3'b000);
    tick(1'b0, 8'h00, 3'b000, 3'b111, 3'b000);
    tick(1'b1, 8'h02, 3'b000, 3'b011, 3'b000);
    tick(1'b1, 8'h02, 3'b000, 3'b011, 3'b000);
    n_cmp++; if ({busy, error} !== 2'b11) begin n_bad++; $display("FAIL arst_pre: got %b want 11", {busy, error}); end
    #1 reset = 1'b1;
    #1;
    n_cmp++; if ({busy, error, write_enb} !== 5'b00000) begin n_bad++; $display("FAIL arst_ctrl: got %b want 00000", {busy, error, write_enb}); end
    n_cmp++; if (hold_data !== 8'h00) begin n_bad++; $display("FAIL arst_hold: got %h want 00", hold_data); end
    tick(1'b0, 8'h00, 3'b000, 3'b111, 3'b000);
    reset = 1'b0;
    tick(1'b0, 8'h00, 3'b000, 3'b111, 3'b000);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL arst_after: got %b want 0", busy); end
  endtask

  task automatic test_soft_reset();
    int first, pulses, others, exp_first, exp_pulses;
`ifdef ROUTER_SOFT_RESET_EN
    exp_first = TIMEOUT; exp_pulses = 1;
`else
    exp_first = -1; exp_pulses = 0;
`endif
    first = -1; pulses = 0; others = 0;
    for (int k = 0; k <= TIMEOUT + 5; k++) begin
      tick(1'b0, 8'h00, 3'b000, 3'b110, 3'b000);
      if (soft_reset[0]) begin pulses++; if (first < 0) first = k; end
      if (soft_reset[2:1] != 2'b00) others++;
    end
    n_cmp++; if (first !== exp_first) begin n_bad++; $display("FAIL sr_first: got %0d want %0d", first, exp_first); end
    n_cmp++; if (pulses !== exp_pulses) begin n_bad++; $display("FAIL sr_pulses: got %0d want %0d", pulses, exp_pulses); end
    n_cmp++; if (others !== 0) begin n_bad++; $display("FAIL sr_other_ports: got %0d want 0", others); end
    tick(1'b0, 8'h00, 3'b000, 3'b111, 3'b000);

    // A read at cycle 20 restarts the count, pushing the pulse to 30 cycles later.
`ifdef ROUTER_SOFT_RESET_EN
    exp_first = 20 + TIMEOUT;
`endif
    first = -1; pulses = 0;
    for (int k = 0; k <= 55; k++) begin
      tick(1'b0, 8'h00, 3'b000, 3'b110, (k == 19) ? 3'b001 : 3'b000);
      if (soft_reset[0]) begin pulses++; if (first < 0) first = k; end
    end
    n_cmp++; if (first !== exp_first) begin n_bad++; $display("FAIL sr_read_first: got %0d want %0d", first, exp_first); end
    n_cmp++; if (pulses !== exp_pulses) begin n_bad++; $display("FAIL sr_read_pulses: got %0d want %0d", pulses, exp_pulses); end
    tick(1'b0, 8'h00, 3'b000, 3'b111, 3'b000);
  endtask

`ifdef ROUTER_SOFT_RESET_EN
  task automatic test_soft_abort();
    tick(1'b1, 8'h00, 3'b000, 3'b110, 3'b000);
    for (int k = 1; k <= TIMEOUT + 1; k++) begin
      tick(1'b0, 8'h00, 3'b000, 3'b110, 3'b000);
      if (k == TIMEOUT) begin
        n_cmp++; if ({soft_reset[0], busy, write_enb} !== 5'b11000) begin n_bad++; $display("FAIL abort_pulse: got %b want 11000", {soft_reset[0], busy, write_enb}); end
      end
      if (k == TIMEOUT + 1) begin
        n_cmp++; if ({busy, write_enb} !== 4'b0000) begin n_bad++; $display("FAIL abort_decode: got %b want 0000", {busy, write_enb}); end
      end
    end
    tick(1'b0, 8'h00, 3'b000, 3'b111, 3'b000);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_good_packet();
    test_parity_error();
    test_wait_empty();
    test_fifo_full();
    test_full_on_parity();
    test_bad_addr();
    test_async_reset();
    test_soft_reset();
`ifdef ROUTER_SOFT_RESET_EN
    test_soft_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
